cellrv32_vector_instr_queue: RTL and testbench
==============================================

Name: cellrv32_vector_instr_queue

Overview:
- Decoupling FIFO between the CPU vector dispatch point and the vector register remapping stage.
- Accepts decoded to_vector instructions from the core and presents the oldest one to the remapper as valid/instr.
- Dequeues only on the remapper's pop strobe.
- Holds reconfigure instructions at the head until the vector backend reports idle, so a vl/maxvl change never overtakes in-flight work. Supports a synchronous flush.

Parameters:
- DEPTH, 4, number of instruction entries; must be a power of two, >= 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy counter; derived, not overridden.

Ports:
- clk_i  input  1  clock.
- rstn_i  input  1  asynchronous active-low reset.
- push_i  input  1  core presents an instruction this cycle.
- instr_i  input  $bits(to_vector)  instruction being pushed.
- ready_o  output  1  queue can accept a push this cycle (not full).
- flush_i  input  1  discard all entries (pipeline squash).
- backend_idle_i  input  1  remapper and all vector lanes are idle.
- valid_o  output  1  head entry available to the remapper.
- instr_o  output  $bits(to_vector)  head entry, driven directly from the storage register.
- pop_i  input  1  remapper consumed the head (its pop strobe).
- count_o  output  CNT_W  current occupancy, 0..DEPTH.
- empty_o  output  1  count_o == 0.
- is_idle_o  output  1  empty_o and no reconfigure barrier pending.

Behaviour:
- Reset (asynchronous, rstn_i low): rd_ptr, wr_ptr and count = 0.
  - Outputs: valid_o = 0, ready_o = 1, empty_o = 1, is_idle_o = 1, count_o = 0.
  - instr_o = storage entry 0; it is don't-care while valid_o = 0.
  - Storage contents are not reset. Reset mid-operation drops all entries.
- Storage: DEPTH-entry register array. wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
- Push: accepted when push_i && ready_o. Entry written at wr_ptr on the clock edge; wr_ptr increments.
  - ready_o = (count != DEPTH), combinational from registered state only; it does not depend on pop_i in the same cycle.
- Head presentation: instr_o = storage[rd_ptr], combinational from registers.
  - Latency from push to valid_o is 1 cycle; there is no same-cycle bypass.
- Reconfigure barrier:
  - head_reconf = (count != 0) && storage[rd_ptr].reconfigure.
  - valid_o = (count != 0) && (!head_reconf || backend_idle_i).
  - A non-reconfigure head is presented unconditionally.
- Pop: performed when pop_i && valid_o; rd_ptr increments.
  - pop_i while valid_o = 0 is ignored; the bench flags it as a protocol error.
  - pop_i may assert in the same cycle valid_o rises (the remapper's pop is combinational from its valid_in).
- Count update:
  - push only: +1.
  - pop only: -1.
  - simultaneous accepted push and pop: unchanged; both pointers advance.
  - When full, push is refused even if a pop occurs that cycle.
  - When empty, a push and a pop cannot coincide, because valid_o = 0.
- Flush: flush_i has priority over push and pop in the same cycle.
  - Next cycle: count = 0, rd_ptr = wr_ptr = 0, valid_o = 0.
  - A push presented in the flush cycle is dropped, and ready_o is still 1 that cycle unless full.
- is_idle_o = (count == 0). Because any pending barrier implies count != 0, is_idle_o covers the barrier case.
- Ordering: strict FIFO. No reordering, and no entry is ever presented twice.

Test Plan:
- Reset, then push A, B, C on consecutive cycles with pop_i tied to valid_o -> valid_o rises 1 cycle after A's push; instr_o shows A, B, C on successive cycles; count_o peaks at 1; empty_o = 1 afterwards.
- DEPTH=4: push 5 instructions with no pop -> ready_o = 0 after the 4th; the 5th is held by the source; count_o = 4. Pop one -> ready_o = 1 next cycle; the 5th enters; the order out is 1, 2, 3, 4, 5 across wrap-around (wr_ptr wraps 3 -> 0).
- Full queue, push_i and pop_i asserted in the same cycle -> push refused, pop performed, count_o = 3. At count 2 with simultaneous push and pop -> count_o stays 2; both pointers advance.
- Head is a reconfigure entry with backend_idle_i = 0 for 5 cycles -> valid_o = 0 and count_o = 1 throughout. backend_idle_i = 1 -> valid_o = 1 in the same cycle; pop accepted; the following normal entry is presented next cycle regardless of backend_idle_i.
- count_o = 3, flush_i = 1 together with push_i = 1 and pop_i = 1 -> next cycle count_o = 0, valid_o = 0, is_idle_o = 1. A new push lands at entry 0 and appears 1 cycle later.
- rstn_i deasserted asynchronously mid-cycle with count_o = 2 -> outputs reach reset values immediately, without waiting for a clock edge. After release, the first push behaves as in the first scenario.

Source files
------------

// File: rtl/cellrv32_vector_instr_queue_if.sv
// Handshake bundle between the core dispatch point, the vector instruction
// queue and the register remapping stage. The queue attaches as slave; the
// environment driving push/pop/flush/idle attaches as master.
interface cellrv32_vector_instr_queue_if #(
   parameter int DEPTH   = 4,
   parameter int INSTR_W = 32
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   // core -> queue
   logic               push_i;
   logic [INSTR_W-1:0] instr_i;
   logic               ready_o;
   logic               flush_i;
   // backend status
   logic               backend_idle_i;
   // queue -> remapper
   logic               valid_o;
   logic [INSTR_W-1:0] instr_o;
   logic               pop_i;
   // occupancy / status
   logic [CNT_W-1:0]   count_o;
   logic               empty_o;
   logic               is_idle_o;

   modport master (
      output push_i, instr_i, flush_i, backend_idle_i, pop_i,
      input  ready_o, valid_o, instr_o, count_o, empty_o, is_idle_o
   );

   modport slave (
      input  push_i, instr_i, flush_i, backend_idle_i, pop_i,
      output ready_o, valid_o, instr_o, count_o, empty_o, is_idle_o
   );
endinterface

// File: rtl/cellrv32_vector_instr_queue.sv
// Vector instruction queue: FIFO decoupling vector dispatch from the register
// remapper. A reconfigure instruction at the head is held back until the vector
// backend is idle so a vl/maxvl change never overtakes in-flight work.
module cellrv32_vector_instr_queue #(
   parameter int DEPTH = 4
) (
   input  logic                          clk_i,
   input  logic                          rstn_i,
   cellrv32_vector_instr_queue_if.slave  vq
);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int PTR_W = $clog2(DEPTH);

   // Decoded instruction as handed over by the core; the reconfigure flag sits
   // in the MSB.
   typedef struct packed {
      logic       reconfigure;
      logic [6:0] opcode;
      logic [4:0] vd;
      logic [4:0] vs1;
      logic [4:0] vs2;
      logic [8:0] funct;
   } to_vector;

   to_vector             storage_reg [DEPTH];
   logic [PTR_W-1:0]     rd_ptr_reg, rd_ptr_next;
   logic [PTR_W-1:0]     wr_ptr_reg, wr_ptr_next;
   logic [CNT_W-1:0]     count_reg,  count_next;

   to_vector             instr_in;
   to_vector             head;
   logic                 full;
   logic                 not_empty;
   logic                 head_reconf;
   logic                 valid;
   logic                 push_ok;
   logic                 pop_ok;

   assign instr_in    = vq.instr_i;
   assign head        = storage_reg[rd_ptr_reg];
   assign full        = (count_reg == CNT_W'(DEPTH));
   assign not_empty   = (count_reg != '0);
   // A reconfigure head waits for the backend; anything else goes straight out.
   assign head_reconf = not_empty && head.reconfigure;
   assign valid       = not_empty && (!head_reconf || vq.backend_idle_i);
   // Flush wins over both sides; full refuses a push even if a pop happens now.
   assign push_ok     = vq.push_i && !full && !vq.flush_i;
   assign pop_ok      = vq.pop_i && valid && !vq.flush_i;

   assign vq.ready_o   = !full;
   assign vq.valid_o   = valid;
   assign vq.instr_o   = head;
   assign vq.count_o   = count_reg;
   assign vq.empty_o   = !not_empty;
   assign vq.is_idle_o = !not_empty;

   // Storage array, written at the tail on an accepted push; never reset.
   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         storage_reg[wr_ptr_reg] <= instr_in;
      end
   end

   // Next-state for pointers and occupancy; flush returns everything to zero.
   always_comb begin
      rd_ptr_next = rd_ptr_reg;
      wr_ptr_next = wr_ptr_reg;
      count_next  = count_reg;
      if (vq.flush_i) begin
         rd_ptr_next = '0;
         wr_ptr_next = '0;
         count_next  = '0;
      end else begin
         if (push_ok) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
         endcase
      end
   end

   // Pointer and occupancy registers; reset drops every entry immediately.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         rd_ptr_reg <= rd_ptr_next;
         wr_ptr_reg <= wr_ptr_next;
         count_reg  <= count_next;
      end
   end
endmodule

// File: tb/tb_cellrv32_vector_instr_queue.sv
// Bench for the vector instruction queue: directed stimulus pushes expected
// instructions into a scoreboard; a negedge monitor compares each popped head.
module tb_cellrv32_vector_instr_queue;
   logic        clk  = 1'b0;
   logic        rstn = 1'b0;
   logic        auto_pop;
   logic        man_pop;
   int          checks   = 0;
   int          failures = 0;
   logic [31:0] sb [$];
   logic [31:0] mon_exp;

   localparam logic [31:0] RCFG = 32'h8000_0000;

   cellrv32_vector_instr_queue_if #(.DEPTH(4), .INSTR_W(32)) vif ();

   cellrv32_vector_instr_queue #(.DEPTH(4)) dut (
      .clk_i  (clk),
      .rstn_i (rstn),
      .vq     (vif)
   );

   always #5 clk = ~clk;

   // remapper model: either pops combinationally on valid, or under bench control
   assign vif.pop_i = auto_pop ? vif.valid_o : man_pop;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_valid"},   32'(vif.valid_o),   32'd0);
      chk({tag, "_ready"},   32'(vif.ready_o),   32'd1);
      chk({tag, "_empty"},   32'(vif.empty_o),   32'd1);
      chk({tag, "_is_idle"}, 32'(vif.is_idle_o), 32'd1);
      chk({tag, "_count"},   32'(vif.count_o),   32'd0);
   endtask

   // Monitor: every accepted pop is compared against the scoreboard head.
   always @(negedge clk) begin
      if (rstn) begin
         if (vif.flush_i) begin
            sb.delete();
         end else if (vif.pop_i) begin
            checks++;
            if (!vif.valid_o) begin
               failures++;
               $display("FAIL pop_protocol valid_o actual=0 required=1");
            end else if (sb.size() == 0) begin
               failures++;
               $display("FAIL sb_pop actual=%08h required=no_entry", vif.instr_o);
            end else begin
               mon_exp = sb.pop_front();
               if (vif.instr_o !== mon_exp) begin
                  failures++;
                  $display("FAIL sb_pop actual=%08h required=%08h", vif.instr_o, mon_exp);
               end else begin
                  $display("pop instr=%08h count=%0d", vif.instr_o, vif.count_o);
               end
            end
         end
      end
   end

   // Three back-to-back pushes drained by a remapper that pops on valid.
   task automatic run_abc(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      auto_pop = 1'b1;
      tick; vif.push_i = 1'b1; vif.instr_i = a; sb.push_back(a);
      @(negedge clk); chk("abc_no_bypass", 32'(vif.valid_o), 32'd0);
      tick; vif.instr_i = b; sb.push_back(b);
      @(negedge clk); chk("abc_valid_lat1", 32'(vif.valid_o), 32'd1);
                      chk("abc_count_a", 32'(vif.count_o), 32'd1);
      tick; vif.instr_i = c; sb.push_back(c);
      @(negedge clk); chk("abc_count_b", 32'(vif.count_o), 32'd1);
      tick; vif.push_i = 1'b0;
      @(negedge clk); chk("abc_count_c", 32'(vif.count_o), 32'd1);
      tick;
      @(negedge clk); chk("abc_empty", 32'(vif.empty_o), 32'd1);
                      chk("abc_count_end", 32'(vif.count_o), 32'd0);
      auto_pop = 1'b0;
   endtask

   initial begin
      vif.push_i = 1'b0; vif.instr_i = '0; vif.flush_i = 1'b0;
      vif.backend_idle_i = 1'b1; auto_pop = 1'b0; man_pop = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); chk_reset_outputs("reset");
      tick; rstn = 1'b1;

      // back-to-back pass-through
      run_abc(32'h0000_00A1, 32'h0000_00B2, 32'h0000_00C3);

      // fill to full, hold a fifth push, wrap around
      for (int i = 1; i <= 4; i++) begin
         tick; vif.push_i = 1'b1; vif.instr_i = 32'h100 + 32'(i); sb.push_back(32'h100 + 32'(i));
      end
      tick; vif.instr_i = 32'h105;
      @(negedge clk); chk("full_ready", 32'(vif.ready_o), 32'd0);
                      chk("full_count", 32'(vif.count_o), 32'd4);
      tick; man_pop = 1'b1;
      @(negedge clk); chk("full_pushpop_ready", 32'(vif.ready_o), 32'd0);
      tick; man_pop = 1'b0;
      @(negedge clk); chk("full_pushpop_count", 32'(vif.count_o), 32'd3);
                      chk("ready_after_pop", 32'(vif.ready_o), 32'd1);
      sb.push_back(32'h105);
      tick; vif.push_i = 1'b0; man_pop = 1'b1;
      @(negedge clk); chk("refill_count", 32'(vif.count_o), 32'd4);
      tick;
      @(negedge clk); chk("drain_count3", 32'(vif.count_o), 32'd3);
      tick; vif.push_i = 1'b1; vif.instr_i = 32'h106; sb.push_back(32'h106);
      @(negedge clk); chk("simul_before", 32'(vif.count_o), 32'd2);
      tick; vif.push_i = 1'b0; man_pop = 1'b0;
      @(negedge clk); chk("simul_count_stays", 32'(vif.count_o), 32'd2);
      tick; auto_pop = 1'b1;
      tick; tick;
      @(negedge clk); chk("wrap_drained", 32'(vif.empty_o), 32'd1);
      auto_pop = 1'b0;

      // reconfigure barrier
      auto_pop = 1'b1; vif.backend_idle_i = 1'b0;
      tick; vif.push_i = 1'b1; vif.instr_i = RCFG | 32'h0CF; sb.push_back(RCFG | 32'h0CF);
      tick; vif.push_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); chk("barrier_valid", 32'(vif.valid_o), 32'd0);
                         chk("barrier_count", 32'(vif.count_o), 32'd1);
         tick;
      end
      vif.push_i = 1'b1; vif.instr_i = 32'h0000_0D0D; sb.push_back(32'h0000_0D0D);
      @(negedge clk); chk("barrier_hold2", 32'(vif.valid_o), 32'd0);
      tick; vif.push_i = 1'b0;
      @(negedge clk); chk("barrier_count2", 32'(vif.count_o), 32'd2);
                      chk("barrier_idle_o", 32'(vif.is_idle_o), 32'd0);
      tick; vif.backend_idle_i = 1'b1;
      @(negedge clk); chk("barrier_release", 32'(vif.valid_o), 32'd1);
      tick; vif.backend_idle_i = 1'b0;
      @(negedge clk); chk("normal_after_rcfg", 32'(vif.valid_o), 32'd1);
      tick;
      @(negedge clk); chk("barrier_drained", 32'(vif.empty_o), 32'd1);
      auto_pop = 1'b0; vif.backend_idle_i = 1'b1;

      // flush with concurrent push and pop
      for (int i = 1; i <= 3; i++) begin
         tick; vif.push_i = 1'b1; vif.instr_i = 32'h200 + 32'(i); sb.push_back(32'h200 + 32'(i));
      end
      tick; vif.push_i = 1'b0;
      @(negedge clk); chk("preflush_count", 32'(vif.count_o), 32'd3);
      tick; vif.flush_i = 1'b1; vif.push_i = 1'b1; vif.instr_i = 32'h2FF; man_pop = 1'b1;
      @(negedge clk); chk("flush_cycle_ready", 32'(vif.ready_o), 32'd1);
      tick; vif.flush_i = 1'b0; vif.push_i = 1'b0; man_pop = 1'b0;
      @(negedge clk); chk("flush_count", 32'(vif.count_o), 32'd0);
                      chk("flush_valid", 32'(vif.valid_o), 32'd0);
                      chk("flush_is_idle", 32'(vif.is_idle_o), 32'd1);
      tick; vif.push_i = 1'b1; vif.instr_i = 32'h300; sb.push_back(32'h300);
      @(negedge clk); chk("postflush_lat0", 32'(vif.valid_o), 32'd0);
      tick; vif.push_i = 1'b0; man_pop = 1'b1;
      @(negedge clk); chk("postflush_valid", 32'(vif.valid_o), 32'd1);
      tick; man_pop = 1'b0;
      @(negedge clk); chk("postflush_empty", 32'(vif.empty_o), 32'd1);

      // asynchronous reset mid-cycle with two entries queued
      tick; vif.push_i = 1'b1; vif.instr_i = 32'h401; sb.push_back(32'h401);
      tick; vif.instr_i = 32'h402; sb.push_back(32'h402);
      tick; vif.push_i = 1'b0;
      @(negedge clk); chk("prereset_count", 32'(vif.count_o), 32'd2);
      #1 rstn = 1'b0; sb.delete();
      #1 chk_reset_outputs("async");
      tick; rstn = 1'b1;
      run_abc(32'h0000_0511, 32'h0000_0522, 32'h0000_0533);

      tick;
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
